// File: rtl/lane_result_filter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lane_result_filter: moving average, scale and saturate of CNN lane results |
// | Optional lane-loss timeout: LANE_FILTER_TIMEOUT_EN.            Rev 1.0     |
// +---------------------------------------------------------------------------+
module lane_result_filter #(
  parameter int AVG_DEPTH      = 4,
  parameter int OUT_SHIFT      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_result_valid,
  input  logic signed [47:0] i_result_data,
  output logic               o_steer_valid,
  input  logic               i_steer_ready,
  output logic signed [15:0] o_steer_data,
  output logic               o_overrun,
  output logic               o_lane_lost,
  output logic        [15:0] o_frame_count
);

  localparam int c_log2_depth = $clog2(AVG_DEPTH);
  localparam int c_sum_w      = 48 + c_log2_depth;
  localparam logic [c_log2_depth-1:0] c_ptr_last = c_log2_depth'(AVG_DEPTH - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                    r_state;
  logic signed [47:0]        r_hist [AVG_DEPTH];
  logic [c_log2_depth-1:0]   r_ptr;
  logic signed [c_sum_w-1:0] r_sum;
  logic                      r_sum_vld;
  logic                      r_steer_valid;
  logic signed [15:0]        r_steer_data;
  logic                      r_overrun;
  logic [15:0]               r_frame_count;

  logic signed [c_sum_w-1:0] w_new_ext;
  logic signed [c_sum_w-1:0] w_old_ext;
  logic signed [c_sum_w-1:0] w_warm_sum;
  logic signed [47:0]        w_avg;
  logic signed [47:0]        w_scaled;
  logic signed [15:0]        w_sat;
  logic                      w_timeout;

  assign w_new_ext  = {{c_log2_depth{i_result_data[47]}}, i_result_data};
  assign w_old_ext  = {{c_log2_depth{r_hist[r_ptr][47]}}, r_hist[r_ptr]};
  assign w_warm_sum = {i_result_data, {c_log2_depth{1'b0}}};

  // Dropping the low log2 bits of the sum is the arithmetic divide by depth.
  assign w_avg    = r_sum[c_sum_w-1:c_log2_depth];
  assign w_scaled = w_avg >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_scaled[15:0];
    if (w_scaled > 48'sd32767) begin
      w_sat = 16'sh7fff;
    end else if (w_scaled < -48'sd32768) begin
      w_sat = 16'sh8000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_ptr         <= '0;
      r_sum         <= '0;
      r_sum_vld     <= 1'b0;
      r_steer_valid <= 1'b0;
      r_steer_data  <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
      for (int k = 0; k < AVG_DEPTH; k++) begin
        r_hist[k] <= '0;
      end
    end else begin
      r_sum_vld <= 1'b0;
      r_overrun <= 1'b0;

      if (i_result_valid) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_sum_vld     <= 1'b1;
        if (r_state == S_EMPTY) begin
          for (int k = 0; k < AVG_DEPTH; k++) begin
            r_hist[k] <= i_result_data;
          end
          r_sum   <= w_warm_sum;
          r_ptr   <= '0;
          r_state <= S_RUN;
        end else begin
          r_hist[r_ptr] <= i_result_data;
          r_sum         <= r_sum + w_new_ext - w_old_ext;
          r_ptr         <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
        end
      end else if (w_timeout) begin
        // Stale history is dropped; the next sample warm-starts the window.
        r_state <= S_EMPTY;
        r_sum   <= '0;
        r_ptr   <= '0;
      end

      if (r_sum_vld) begin
        r_steer_valid <= 1'b1;
        r_steer_data  <= w_sat;
        r_overrun     <= r_steer_valid && !i_steer_ready;
      end else if (r_steer_valid && i_steer_ready) begin
        r_steer_valid <= 1'b0;
      end
    end
  end

`ifdef LANE_FILTER_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_lane_lost;

  assign w_timeout = (r_state == S_RUN) && !i_result_valid && (r_to_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt    <= '0;
      r_lane_lost <= 1'b0;
    end else if (i_result_valid) begin
      r_to_cnt    <= '0;
      r_lane_lost <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_timeout) begin
        r_to_cnt    <= '0;
        r_lane_lost <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign o_lane_lost = r_lane_lost;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign o_lane_lost      = 1'b0;
`endif

  assign o_steer_valid = r_steer_valid;
  assign o_steer_data  = r_steer_data;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_lane_result_filter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for lane_result_filter: window/scale/saturate reference model, handshake,
// reset and (when LANE_FILTER_TIMEOUT_EN is defined) lane-loss scenarios.
module tb_lane_result_filter;

  localparam int AVG_DEPTH      = 4;
  localparam int OUT_SHIFT      = 16;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int LOG2_DEPTH     = $clog2(AVG_DEPTH);

  logic               clk = 1'b0;
  logic               rst;
  logic               i_result_valid;
  logic signed [47:0] i_result_data;
  logic               o_steer_valid;
  logic               i_steer_ready;
  logic signed [15:0] o_steer_data;
  logic               o_overrun;
  logic               o_lane_lost;
  logic        [15:0] o_frame_count;

  int errors = 0;
  int checks = 0;
  longint win[$];
  int exp_frames = 0;

  lane_result_filter #(
    .AVG_DEPTH     (AVG_DEPTH),
    .OUT_SHIFT     (OUT_SHIFT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_result_valid(i_result_valid),
    .i_result_data (i_result_data),
    .o_steer_valid (o_steer_valid),
    .i_steer_ready (i_steer_ready),
    .o_steer_data  (o_steer_data),
    .o_overrun     (o_overrun),
    .o_lane_lost   (o_lane_lost),
    .o_frame_count (o_frame_count)
  );

  always #5 clk = ~clk;

  // Reference: window of the last AVG_DEPTH samples, filled with copies when empty.
  function automatic logic signed [15:0] model_push(input logic signed [47:0] d);
    longint s, sum, scaled;
    s = longint'(d);
    if (win.size() == 0) begin
      for (int k = 0; k < AVG_DEPTH; k++) win.push_back(s);
    end else begin
      win.push_back(s);
      void'(win.pop_front());
    end
    sum = 0;
    foreach (win[k]) sum += win[k];
    scaled = (sum >>> LOG2_DEPTH) >>> OUT_SHIFT;
    if (scaled > 32767) return 16'sh7fff;
    if (scaled < -32768) return 16'sh8000;
    return scaled[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic junk_data;
    logic [63:0] r;
    r = {$urandom, $urandom};
    i_result_data = r[47:0];
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    i_result_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    win.delete();
    exp_frames = 0;
  endtask

  task automatic drive_sample(input logic signed [47:0] d);
    i_result_valid = 1'b1;
    i_result_data  = d;
    tick;
    i_result_valid = 1'b0;
    exp_frames++;
    junk_data;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({o_steer_valid, o_overrun, o_lane_lost} !== 3'b000 || o_steer_data !== 16'sd0 || o_frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ovr=%b lost=%b data=%0d frames=%0d, expected all 0",
               o_steer_valid, o_overrun, o_lane_lost, o_steer_data, o_frame_count);
    end
  endtask

  task automatic test_warm_start;
    logic signed [15:0] e;
    apply_reset;
    i_steer_ready = 1'b1;
    e = model_push(48'sh0000_0005_0000);
    drive_sample(48'sh0000_0005_0000);
    checks++;
    if (o_steer_valid !== 1'b0) begin
      errors++;
      $display("FAIL warm_latency1: valid=%b expected 0 one cycle after sample", o_steer_valid);
    end
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== 16'sd5 || e !== 16'sd5) begin
      errors++;
      $display("FAIL warm_output: valid=%b data=%0d model=%0d expected 1/5", o_steer_valid, o_steer_data, e);
    end
    checks++;
    if (o_frame_count !== 16'd1) begin
      errors++;
      $display("FAIL warm_frames: got %0d expected 1", o_frame_count);
    end
  endtask

  task automatic test_averaging;
    logic signed [47:0] seq [3];
    logic signed [15:0] lit [3];
    logic signed [15:0] e;
    seq[0] = 48'sd4 <<< 16; seq[1] = 48'sd8 <<< 16; seq[2] = 48'sd8 <<< 16;
    lit[0] = 16'sd4;        lit[1] = 16'sd5;        lit[2] = 16'sd6;
    apply_reset;
    i_steer_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = model_push(seq[i]);
      drive_sample(seq[i]);
      tick;
      checks++;
      if (o_steer_valid !== 1'b1 || o_steer_data !== lit[i] || e !== lit[i]) begin
        errors++;
        $display("FAIL average_%0d: valid=%b data=%0d model=%0d expected %0d", i, o_steer_valid, o_steer_data, e, lit[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic signed [47:0] smp [2];
    logic signed [15:0] lit [2];
    smp[0] = 48'sh7FFF_FFFF_FFFF; lit[0] = 16'sh7fff;
    smp[1] = 48'sh8000_0000_0000; lit[1] = 16'sh8000;
    for (int i = 0; i < 2; i++) begin
      apply_reset;
      i_steer_ready = 1'b1;
      drive_sample(smp[i]);
      tick;
      checks++;
      if (o_steer_valid !== 1'b1 || o_steer_data !== lit[i]) begin
        errors++;
        $display("FAIL saturate_%0d: valid=%b data=%0d expected %0d", i, o_steer_valid, o_steer_data, lit[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] r;
    longint v;
    logic signed [47:0] d;
    logic signed [15:0] e;
    int bad;
    apply_reset;
    i_steer_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      v = longint'(r) >>> (16 + $urandom_range(0, 30));
      d = v[47:0];
      e = model_push(d);
      drive_sample(d);
      tick;
      if (o_steer_valid !== 1'b1 || o_steer_data !== e) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_%0d: valid=%b data=%0d expected %0d", i, o_steer_valid, o_steer_data, e);
      end
      repeat ($urandom_range(0, 2)) tick;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (o_frame_count !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL random_frames: got %0d expected %0d", o_frame_count, exp_frames);
    end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] ea, eb, ec, ed;
    apply_reset;
    i_steer_ready = 1'b0;
    ea = model_push(48'sd3 <<< 16);
    drive_sample(48'sd3 <<< 16);
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== ea || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: valid=%b data=%0d ovr=%b expected 1/%0d/0", o_steer_valid, o_steer_data, o_overrun, ea);
    end
    eb = model_push(48'sd11 <<< 16);
    drive_sample(48'sd11 <<< 16);
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== ea) begin
      errors++;
      $display("FAIL bp_hold_first: valid=%b data=%0d expected 1/%0d", o_steer_valid, o_steer_data, ea);
    end
    tick;
    checks++;
    if (o_overrun !== 1'b1 || o_steer_data !== eb) begin
      errors++;
      $display("FAIL bp_overrun: ovr=%b data=%0d expected 1/%0d", o_overrun, o_steer_data, eb);
    end
    repeat (4) tick;
    checks++;
    if (o_overrun !== 1'b0 || o_steer_valid !== 1'b1 || o_steer_data !== eb) begin
      errors++;
      $display("FAIL bp_hold_second: ovr=%b valid=%b data=%0d expected 0/1/%0d", o_overrun, o_steer_valid, o_steer_data, eb);
    end
    i_steer_ready = 1'b1;
    tick;
    checks++;
    if (o_steer_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b expected 0", o_steer_valid);
    end
    // Consecutive samples: second load coincides with the first handshake.
    ec = model_push(-(48'sd7 <<< 16));
    ed = model_push(48'sd20 <<< 16);
    i_result_valid = 1'b1;
    i_result_data  = -(48'sd7 <<< 16);
    tick;
    i_result_data  = 48'sd20 <<< 16;
    tick;
    i_result_valid = 1'b0;
    exp_frames += 2;
    junk_data;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== ec) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%0d expected 1/%0d", o_steer_valid, o_steer_data, ec);
    end
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== ed || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%0d ovr=%b expected 1/%0d/0", o_steer_valid, o_steer_data, o_overrun, ed);
    end
    tick;
    checks++;
    if (o_steer_valid !== 1'b0 || o_frame_count !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b frames=%0d expected 0/%0d", o_steer_valid, o_frame_count, exp_frames);
    end
  endtask

  task automatic test_timeout;
    logic signed [15:0] e;
    apply_reset;
    i_steer_ready = 1'b1;
    e = model_push(48'sd5 <<< 16);
    drive_sample(48'sd5 <<< 16);
`ifdef LANE_FILTER_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) tick;
    checks++;
    if (o_lane_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: lost=%b expected 0 after %0d idle cycles", o_lane_lost, TIMEOUT_CYCLES - 1);
    end
    tick;
    checks++;
    if (o_lane_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_lost: lost=%b expected 1 after %0d idle cycles", o_lane_lost, TIMEOUT_CYCLES);
    end
    win.delete();
    e = model_push(48'sd2 <<< 16);
    drive_sample(48'sd2 <<< 16);
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== 16'sd2 || e !== 16'sd2 || o_lane_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: valid=%b data=%0d lost=%b expected 1/2/0", o_steer_valid, o_steer_data, o_lane_lost);
    end
`else
    repeat (2 * TIMEOUT_CYCLES) tick;
    checks++;
    if (o_lane_lost !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_lost: lost=%b expected 0", o_lane_lost);
    end
    e = model_push(48'sd2 <<< 16);
    drive_sample(48'sd2 <<< 16);
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== e) begin
      errors++;
      $display("FAIL no_timeout_window: valid=%b data=%0d expected 1/%0d", o_steer_valid, o_steer_data, e);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic signed [15:0] e;
    apply_reset;
    i_steer_ready = 1'b1;
    drive_sample(48'sd7 <<< 16);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    win.delete();
    exp_frames = 0;
    checks++;
    if ({o_steer_valid, o_overrun, o_lane_lost} !== 3'b000 || o_steer_data !== 16'sd0 || o_frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ovr=%b lost=%b data=%0d frames=%0d expected all 0",
               o_steer_valid, o_overrun, o_lane_lost, o_steer_data, o_frame_count);
    end
    repeat (3) tick;
    checks++;
    if (o_steer_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_late: valid=%b expected 0", o_steer_valid);
    end
    rst = 1'b1;
    i_result_valid = 1'b1;
    i_result_data  = 48'sd9 <<< 16;
    tick;
    rst = 1'b0;
    i_result_valid = 1'b0;
    repeat (3) tick;
    checks++;
    if (o_steer_valid !== 1'b0 || o_frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_discard: valid=%b frames=%0d expected 0/0", o_steer_valid, o_frame_count);
    end
    e = model_push(48'sd3 <<< 16);
    drive_sample(48'sd3 <<< 16);
    tick;
    checks++;
    if (o_steer_valid !== 1'b1 || o_steer_data !== e || o_frame_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_rewarm: valid=%b data=%0d frames=%0d expected 1/%0d/1", o_steer_valid, o_steer_data, o_frame_count, e);
    end
  endtask

  initial begin
    rst            = 1'b1;
    i_result_valid = 1'b0;
    i_result_data  = '0;
    i_steer_ready  = 1'b1;
    test_reset;
    test_warm_start;
    test_averaging;
    test_saturation;
    test_random;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lane_result_filter.md
LANE_RESULT_FILTER -- requirements
Module: lane_result_filter

Interface
REQ-001 Parameter AVG_DEPTH, default 4, sets the moving-average window length; legal values are 2, 4, 8 and 16.
REQ-002 Parameter OUT_SHIFT, default 16, sets the arithmetic right shift applied to the averaged value before saturation.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, sets the idle cycles after the last accepted sample before lane loss is declared.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_result_valid  input  1  one-cycle pulse marking a new lane result; driven by the CNN top-level final_result_valid.
REQ-007 i_result_data  input  48 signed  lane result from the FC layer; sampled only when i_result_valid=1.
REQ-008 o_steer_valid  output  1  steering word available.
REQ-009 i_steer_ready  input  1  consumer accepts o_steer_data when o_steer_valid=1 and i_steer_ready=1.
REQ-010 o_steer_data  output  16 signed  filtered, scaled and saturated steering value.
REQ-011 o_overrun  output  1  one-cycle pulse when a pending unaccepted word is overwritten.
REQ-012 o_lane_lost  output  1  level, high while the timeout condition holds.
REQ-013 o_frame_count  output  16  accepted-sample counter; wraps from 0xFFFF to 0.

Function
REQ-014 The FSM shall have two states: EMPTY (no history) and RUN; the state after reset shall be EMPTY.
REQ-015 In EMPTY, a sample shall warm-start the window: all AVG_DEPTH history entries are loaded with it, sum = AVG_DEPTH*sample, and the FSM goes to RUN.
REQ-016 In RUN, a sample shall replace the oldest entry through a circular write pointer that wraps at AVG_DEPTH-1, and shall update sum = sum + new - oldest in the same cycle.
REQ-017 The sum register shall be 48+log2(AVG_DEPTH) bits signed and shall never overflow.
REQ-018 One cycle after the sum update, the block shall compute avg = sum >>> log2(AVG_DEPTH), then scaled = avg >>> OUT_SHIFT (arithmetic, truncation toward minus infinity).
REQ-019 It shall then saturate scaled to [-32768, 32767] into o_steer_data.
REQ-020 The latency from the i_result_valid cycle to o_steer_valid=1 shall be exactly 2 cycles.
REQ-021 o_steer_valid and o_steer_data shall remain stable until the handshake completes; o_steer_valid shall fall in the cycle after the handshake unless a new word loads in that same cycle.
REQ-022 If a new word loads while the pending word is unaccepted and i_steer_ready=0, the new word shall overwrite it and o_overrun shall pulse for one cycle.
REQ-023 If a load and a handshake coincide, the block shall not pulse o_overrun and o_steer_valid shall stay 1 with the new data.
REQ-024 o_frame_count shall increment by 1 on every accepted i_result_valid, including in EMPTY.
REQ-025 The block shall ignore i_result_data whenever i_result_valid=0.

Reset
REQ-026 When rst=1 at a clock edge, the block shall clear state to EMPTY and clear history, sum, pointer, pipeline, o_steer_valid, o_steer_data, o_overrun, o_lane_lost, o_frame_count and the timeout counter, all to 0.
REQ-027 Reset shall abort any in-flight sample mid-pipeline with no output produced.
REQ-028 An i_result_valid pulse coincident with rst=1 shall be discarded.

Configuration
REQ-029 With macro LANE_FILTER_TIMEOUT_EN defined, a counter shall run in RUN, clear on each accepted sample, and behave as follows when it reaches TIMEOUT_CYCLES:
- o_lane_lost goes to 1;
- the FSM returns to EMPTY;
- the history is invalidated.
REQ-030 With the macro defined, o_lane_lost shall clear on the next accepted sample, which warm-starts the window.
REQ-031 Without the macro, the block shall contain no timeout counter, o_lane_lost shall be constant 0, and RUN shall be left only by reset.

Verification
REQ-032 The bench shall cover warm start: reset, then one sample 0x0000_0005_0000 (327680) -> o_steer_valid high 2 cycles later with o_steer_data=5, and o_frame_count=1.
REQ-033 The bench shall cover averaging: with AVG_DEPTH=4, warm start with 4<<16, then samples 8<<16, 8<<16 -> outputs 5, then 6.
REQ-034 The bench shall cover saturation: sample 0x7FFF_FFFF_FFFF -> 32767; sample 0x8000_0000_0000 after reset -> -32768.
REQ-035 The bench shall cover back-pressure: hold i_steer_ready=0 across two samples -> one o_overrun pulse, and the second value is held until ready rises.
REQ-036 The bench shall cover timeout (macro on, TIMEOUT_CYCLES=20): no sample for 20 cycles in RUN -> o_lane_lost=1; the next sample of 2<<16 gives output 2 and o_lane_lost=0.
REQ-037 The bench shall cover reset mid-operation: assert rst 1 cycle after i_result_valid -> no o_steer_valid and all outputs 0.
